// File: rtl/srt_pkg.sv
// Definitions shared by the serial transmitter and receiver: the frame state
// encoding, the parity-mode constants and the parity helper.
package srt_pkg;

   localparam logic [2:0] SRT_IDLE   = 3'd0;
   localparam logic [2:0] SRT_START  = 3'd1;
   localparam logic [2:0] SRT_DATA   = 3'd2;
   localparam logic [2:0] SRT_PARITY = 3'd3;
   localparam logic [2:0] SRT_STOP   = 3'd4;
   localparam logic [2:0] SRT_DONE   = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = SRT_IDLE,
      ST_START  = SRT_START,
      ST_DATA   = SRT_DATA,
      ST_PARITY = SRT_PARITY,
      ST_STOP   = SRT_STOP,
      ST_DONE   = SRT_DONE
   } srt_state_e;

   localparam logic PARITY_MODE_EVEN = 1'b0;
   localparam logic PARITY_MODE_ODD  = 1'b1;

   // data_xor is the XOR reduction of the data word.
   function automatic logic frame_parity(input logic data_xor, input logic odd_mode);
      return data_xor ^ odd_mode;
   endfunction

endpackage

// File: rtl/stsystem_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1, wraps, and pulses tick_o on the last
// count. clr_i forces the count back to zero at the next edge.
module stsystem_baud_cnt #(
   parameter int CLK_DIV = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   assign tick_o = (cnt_q == LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/stsystem_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, parity bit,
// stop bit, each held CLK_DIV clocks, followed by a done/ack handshake.
module stsystem_tx
   import srt_pkg::*;
#(
   parameter int   DATA_W     = 8,
   parameter int   CLK_DIV    = 16,
   parameter logic PARITY_ODD = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              st,
   input  logic [DATA_W-1:0] din,
   input  logic              ack,
   output logic              txd,
   output logic              busy,
   output logic              done
);

   localparam int BW = (DATA_W > 0) ? $clog2(DATA_W + 1) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   srt_state_e        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              par_q, par_d;
   logic              txd_q, txd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              baud_clr;
   logic              baud_tick;

   // Hold the bit timer at zero while not framing and restart it on every state change.
   assign baud_clr = (state_q != state_d) || (state_q == ST_IDLE) || (state_q == ST_DONE);

   stsystem_baud_cnt #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (baud_clr),
      .tick_o (baud_tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      par_d   = par_q;
      case (state_q)
         ST_IDLE: begin
            if (en && st) begin
               shift_d = din;
               par_d   = frame_parity(^din, PARITY_ODD);
               bit_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (baud_tick) begin
               if (bit_q == LAST_BIT) begin
                  state_d = ST_PARITY;
               end else begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (baud_tick) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (baud_tick) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they change on the same edge as the state.
      txd_d  = 1'b1;
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         ST_START: begin
            txd_d  = 1'b0;
            busy_d = 1'b1;
         end
         ST_DATA: begin
            txd_d  = shift_d[0];
            busy_d = 1'b1;
         end
         ST_PARITY: begin
            txd_d  = par_d;
            busy_d = 1'b1;
         end
         ST_STOP: begin
            busy_d = 1'b1;
         end
         ST_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            txd_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign txd  = txd_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_stsystem_tx.sv
// Frame-level bench for stsystem_tx: an even- and an odd-parity instance share
// stimulus and are compared against expected serial frames built from the data word.
module tb_stsystem_tx;

   localparam int DATA_W  = 8;
   localparam int CLK_DIV = 4;
   localparam int NBITS   = DATA_W + 3;
   localparam int FRAME   = NBITS * CLK_DIV;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en  = 1'b0;
   logic              st  = 1'b0;
   logic [DATA_W-1:0] din = '0;
   logic              ack = 1'b0;
   logic              txd_e, busy_e, done_e;
   logic              txd_o, busy_o, done_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stsystem_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .PARITY_ODD(1'b0)) dut_even (
      .clk(clk), .rst(rst), .en(en), .st(st), .din(din), .ack(ack),
      .txd(txd_e), .busy(busy_e), .done(done_e)
   );

   stsystem_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .rst(rst), .en(en), .st(st), .din(din), .ack(ack),
      .txd(txd_o), .busy(busy_o), .done(done_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Serial frame as a bit vector, index 0 transmitted first.
   function automatic logic [NBITS-1:0] frame_bits(input logic [DATA_W-1:0] d, input logic odd);
      logic [NBITS-1:0] b;
      b[0]          = 1'b0;
      b[DATA_W:1]   = d;
      b[DATA_W+1]   = (^d) ^ odd;
      b[DATA_W+2]   = 1'b1;
      return b;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_txd_e"},  txd_e,  1'b1);
      check({tag, "_txd_o"},  txd_o,  1'b1);
      check({tag, "_busy_e"}, busy_e, 1'b0);
      check({tag, "_busy_o"}, busy_o, 1'b0);
      check({tag, "_done_e"}, done_e, 1'b0);
      check({tag, "_done_o"}, done_o, 1'b0);
   endtask

   // Entered and left at a negedge with the DUTs idle.
   // mode 0: quiet line; 1: st pulses, din and en changes mid-frame; 2: random noise.
   task automatic run_frame(input logic [DATA_W-1:0] data, input int mode,
                            input int ack_delay, input logic ack_with_st);
      logic [NBITS-1:0] fe, fo;
      fe = frame_bits(data, 1'b0);
      fo = frame_bits(data, 1'b1);
      check_idle("pre");
      en  = 1'b1;
      st  = 1'b1;
      din = data;
      @(negedge clk);
      st = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         check("txd_even", txd_e, fe[k / CLK_DIV]);
         check("txd_odd",  txd_o, fo[k / CLK_DIV]);
         check("busy_e",   busy_e, 1'b1);
         check("busy_o",   busy_o, 1'b1);
         check("done_e",   done_e, 1'b0);
         if (mode == 1) begin
            st = (k == 5 || k == 20);
            if (k == 5)  din = 8'hFF;
            if (k == 10) en = 1'b0;
            ack = (k == 30);
         end else if (mode == 2) begin
            st  = 1'($urandom_range(0, 1));
            din = DATA_W'($urandom);
            en  = 1'($urandom_range(0, 1));
            ack = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      ack = 1'b0;
      check("end_busy_e", busy_e, 1'b0);
      check("end_done_e", done_e, 1'b1);
      check("end_done_o", done_o, 1'b1);
      check("end_txd_e",  txd_e,  1'b1);
      for (int d = 0; d < ack_delay; d++) begin
         st = 1'($urandom_range(0, 1));
         en = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("hold_done", done_e, 1'b1);
         check("hold_txd",  txd_e,  1'b1);
         check("hold_busy", busy_e, 1'b0);
      end
      ack = 1'b1;
      st  = ack_with_st;
      en  = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      st  = 1'b0;
      check_idle("post_ack");
      $display("frame din=%02h mode=%0d ack_delay=%0d ack_with_st=%0d checks=%0d errors=%0d",
               data, mode, ack_delay, ack_with_st, checks, errors);
   endtask

   initial begin
      #1 rst = 1'b0;
      #2 check_idle("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Requests without en are not accepted.
      en = 1'b0;
      st = 1'b1;
      din = 8'h5A;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("noen_txd",  txd_e,  1'b1);
         check("noen_busy", busy_e, 1'b0);
      end
      st = 1'b0;
      $display("en=0 request window done checks=%0d errors=%0d", checks, errors);

      run_frame(8'hA5, 0, 0, 1'b0);
      run_frame(8'hA5, 1, 10, 1'b1);
      run_frame(8'h07, 0, 2, 1'b0);

      // Abort during data bit 3; outputs must return to idle without a clock edge.
      en  = 1'b1;
      st  = 1'b1;
      din = 8'h96;
      @(negedge clk);
      st = 1'b0;
      repeat (CLK_DIV * 4 + 1) @(negedge clk);
      check("abort_busy_pre", busy_e, 1'b1);
      rst = 1'b0;
      #1;
      check_idle("abort");
      $display("abort mid-frame checks=%0d errors=%0d", checks, errors);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_frame(8'h3C, 0, 1, 1'b0);

      for (int n = 0; n < 20; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            en = 1'b0;
            st = 1'b1;
            repeat ($urandom_range(1, 4)) begin
               @(negedge clk);
               check("rnd_noen_txd", txd_e, 1'b1);
               check("rnd_noen_busy", busy_e, 1'b0);
            end
            st = 1'b0;
         end
         run_frame(DATA_W'($urandom), 2, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
